if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller that drives the instruction memory's read port (`IM`: `addr`, `rd_en`, `instr`) and delivers one instruction per cycle to decode.

- Owns the program counter.
- Handles decode stalls, branch redirects and halt.
- Keeps PC/instruction pairs aligned across bubbles.
- Sits between `IM` and the IF/ID boundary of the single-cycle datapath.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `HLT_OPCODE`, 4'hF, opcode in `instr[15:12]` that halts fetch.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  decode cannot accept; hold fetch state.
- `redirect`  input  1  branch/jump taken; load `redirect_pc`.
- `redirect_pc`  input  16  redirect target.
- `im_addr`  output  16  word address to `IM` (equals current PC).
- `im_rd_en`  output  1  read enable to `IM`.
- `im_instr`  input  16  `IM` read data; valid by end of the cycle the address was driven.
- `if_instr`  output  16  captured instruction.
- `if_pc`  output  16  address of `if_instr`.
- `if_pc_plus1`  output  16  `if_pc` + 1, mod 2^16.
- `if_valid`  output  1  `if_instr` is architecturally valid.
- `halted`  output  1  fetch stopped on HLT.

## Operation
- States: RUN, HALT.
- Reset (async, `rst_n`=0), regardless of state or in-flight fetch:
  - `pc` = `RESET_PC`.
  - `if_instr` = 16'h0000, `if_pc` = 16'h0000, `if_pc_plus1` = 16'h0001.
  - `if_valid` = 0, `halted` = 0, state = RUN.
- Combinational memory outputs:
  - `im_addr` = `pc`.
  - `im_rd_en` = 1 when state = RUN and `stall` = 0; otherwise 0.
- RUN cycle priority (highest first):
  1. `redirect`=1:
     - `pc` ← `redirect_pc`.
     - `if_valid` ← 0; the wrong-path word is squashed.
     - `if_instr`/`if_pc`/`if_pc_plus1` hold.
     - Applies even when `stall`=1.
  2. `stall`=1: all registers hold, including `if_valid`.
  3. Otherwise:
     - `if_instr` ← `im_instr`, `if_pc` ← `pc`, `if_pc_plus1` ← `pc`+1, `if_valid` ← 1.
     - `pc` ← `pc`+1, wrapping 16'hFFFF → 16'h0000.
- HLT capture (only if `HALT_DETECT_EN`), when a fetch completes with `im_instr[15:12]` = `HLT_OPCODE`:
  - The HLT word is delivered with `if_valid`=1.
  - `pc` stays at the HLT address.
  - State → HALT, `halted` ← 1.
- HLT in the same cycle as `redirect`: the HLT is squashed, no halt.
- HALT state:
  - `im_rd_en`=0; `if_valid` ← 0 on the next edge.
  - `redirect` and `stall` are ignored.
  - Only reset exits.

## Timing
- Fetch latency is one cycle: address driven in cycle N → instruction on `if_*` after the rising edge ending cycle N.
- Throughput is one instruction per cycle with no stall or redirect.
- Redirect bubble: exactly one cycle of `if_valid`=0. The target instruction appears with `if_valid`=1 two edges after `redirect` is sampled, provided no stall.
- Stall: `if_*` outputs are stable for every stalled cycle; fetch resumes at the held `pc` on the first non-stalled cycle.
- `halted` asserts on the same edge that presents the HLT instruction.
- Reset deassertion: the first fetch (`RESET_PC`) is issued in the first cycle after `rst_n` rises.

## Configuration
- `IF_HALT_DETECT_EN` defined:
  - HLT detection, HALT state and the `halted` output behave as above.
- `IF_HALT_DETECT_EN` undefined:
  - No opcode decode; state is permanently RUN.
  - `halted` is tied to 0.
  - `HLT_OPCODE` words pass through as ordinary instructions.

## Structure
- Shared package `if_pkg`:
  - `RESET_PC` default.
  - `HLT_OPCODE`.
  - NOP encoding 16'h0000.
  - Fetch state typedef (RUN/HALT).
- Single sub-module: `pc_reg`, the 16-bit PC register with async reset, hold, load and increment-with-wrap.
- All other logic lives in `if_fetch_ctrl`.

## Test plan
- Reset then free-run with memory = address → `if_pc` 0, 1, 2, 3 on consecutive edges, `if_instr` = `if_pc`, `if_valid`=1 from the first edge.
- `stall` held for 3 cycles at `pc`=5 → `if_*` frozen at pc 4, `im_rd_en`=0; pc 5 delivered on the cycle after `stall` falls.
- `redirect`=1 with `redirect_pc`=16'h0100 at `pc`=8 → one bubble (`if_valid`=0), then `if_pc`=16'h0100, then 16'h0101.
- `pc`=16'hFFFF → `if_pc`=16'hFFFF, `if_pc_plus1`=16'h0000, next fetch at 16'h0000.
- `IF_HALT_DETECT_EN` defined, `F000` at address 6:
  - Delivered with `if_valid`=1 and `halted`=1; `im_rd_en`=0 afterwards.
  - A later `redirect` is ignored.
  - Repeated with `redirect` asserted on the HLT cycle → no halt, target fetched.
- `rst_n` pulsed low mid-stall at `pc`=20 → outputs immediately at reset values; fetch restarts at 0.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants, fetch state type and PC helper for the fetch controller
package if_pkg;

    localparam logic [15:0] IF_RESET_PC   = 16'h0000;
    localparam logic [3:0]  IF_HLT_OPCODE = 4'hF;
    localparam logic [15:0] IF_NOP        = 16'h0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    // Word-address increment; the 16-bit result wraps FFFF -> 0000 naturally.
    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_pc_reg.sv
// rtl/if_fetch_ctrl_pc_reg.sv - 16-bit program counter with async reset, hold, load and wrap-increment
module pc_reg
    import if_pkg::*;
#(
    parameter logic [15:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] load_pc_i,
    input  logic        inc_i,
    output logic [15:0] pc_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_inc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller; HLT detection enabled by IF_HALT_DETECT_EN
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = IF_RESET_PC,
    parameter logic [3:0]  HLT_OPCODE = IF_HLT_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_instr,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted
);

    fetch_state_e state_q;
    logic [15:0]  pc;
    logic [15:0]  if_instr_q;
    logic [15:0]  if_pc_q;
    logic [15:0]  if_pc_plus1_q;
    logic         if_valid_q;
    logic         halted_q;

    logic run;
    logic fetch;
    logic hlt_hit;
    logic pc_load;
    logic pc_inc_en;

    assign run   = (state_q == FETCH_RUN);
    // Redirect wins over stall, so a completed fetch needs neither.
    assign fetch = run && !redirect && !stall;

`ifdef IF_HALT_DETECT_EN
    assign hlt_hit = fetch && (im_instr[15:12] == HLT_OPCODE);
`else
    logic unused_hlt_opcode;
    assign hlt_hit           = 1'b0;
    assign unused_hlt_opcode = ^HLT_OPCODE;
`endif

    // PC parks on the HLT word so im_addr keeps pointing at it while halted.
    assign pc_load   = run && redirect;
    assign pc_inc_en = fetch && !hlt_hit;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .inc_i     (pc_inc_en),
        .pc_o      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_RUN;
            if_instr_q    <= IF_NOP;
            if_pc_q       <= 16'h0000;
            if_pc_plus1_q <= 16'h0001;
            if_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else if (state_q == FETCH_RUN) begin
            if (redirect) begin
                if_valid_q <= 1'b0;
            end else if (!stall) begin
                if_instr_q    <= im_instr;
                if_pc_q       <= pc;
                if_pc_plus1_q <= pc_inc(pc);
                if_valid_q    <= 1'b1;
                if (hlt_hit) begin
                    state_q  <= FETCH_HALT;
                    halted_q <= 1'b1;
                end
            end
        end else begin
            if_valid_q <= 1'b0;
        end
    end

    assign im_addr     = pc;
    assign im_rd_en    = run && !stall;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus1 = if_pc_plus1_q;
    assign if_valid    = if_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl with a behavioural fetch model
module tb_if_fetch_ctrl;

`ifdef IF_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic        if_valid;
    logic        halted;

    logic        hlt_on = 1'b0;
    logic [15:0] hlt_addr = 16'h0006;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instruction memory: each word holds its own address, optionally one HLT word.
    assign im_instr = (hlt_on && im_addr == hlt_addr) ? 16'hF000 : im_addr;

    if_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_addr     (im_addr),
        .im_rd_en    (im_rd_en),
        .im_instr    (im_instr),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus1 (if_pc_plus1),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (hlt_on && a == hlt_addr) ? 16'hF000 : a;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of what decode should see.
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_ifpc = 16'h0000;
    logic        m_valid = 1'b0;
    logic        m_halt = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] w;
        if (!rst_n) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000;
            m_valid = 1'b0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else if (redirect) begin
            m_pc = redirect_pc;
            m_valid = 1'b0;
        end else if (!stall) begin
            w = mem_word(m_pc);
            m_instr = w;
            m_ifpc = m_pc;
            m_valid = 1'b1;
            if (HALT_EN && w[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd1;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("model im_addr", im_addr, m_pc);
        chk("model im_rd_en", {15'd0, im_rd_en}, {15'd0, !m_halt && !stall});
        chk("model if_valid", {15'd0, if_valid}, {15'd0, m_valid});
        chk("model if_pc", if_pc, m_ifpc);
        chk("model if_pc_plus1", if_pc_plus1, m_ifpc + 16'd1);
        chk("model if_instr", if_instr, m_instr);
        chk("model halted", {15'd0, halted}, {15'd0, m_halt});
    end

    task automatic edge_chk(input string name, input logic [15:0] pc_exp, input logic v_exp);
        @(posedge clk);
        #3;
        chk({name, " if_pc"}, if_pc, pc_exp);
        chk({name, " if_valid"}, {15'd0, if_valid}, {15'd0, v_exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset if_pc", if_pc, 16'h0000);
        chk("reset if_pc_plus1", if_pc_plus1, 16'h0001);
        chk("reset if_valid", {15'd0, if_valid}, 16'h0000);
        chk("reset halted", {15'd0, halted}, 16'h0000);
        chk("reset im_addr", im_addr, 16'h0000);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            edge_chk("freerun", 16'(k), 1'b1);
            chk("freerun if_instr", if_instr, 16'(k));
        end

        @(negedge clk);
        stall = 1'b1;
        #1 chk("stall im_rd_en", {15'd0, im_rd_en}, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            edge_chk("stalled", 16'h0004, 1'b1);
            chk("stalled if_instr", if_instr, 16'h0004);
        end
        @(negedge clk);
        stall = 1'b0;
        edge_chk("resume", 16'h0005, 1'b1);
        edge_chk("run6", 16'h0006, 1'b1);
        edge_chk("run7", 16'h0007, 1'b1);

        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0100;
        edge_chk("bubble", 16'h0007, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        edge_chk("target", 16'h0100, 1'b1);
        chk("target if_instr", if_instr, 16'h0100);
        edge_chk("target+1", 16'h0101, 1'b1);

        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        edge_chk("wrap bubble", 16'h0101, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        edge_chk("wrap fffe", 16'hFFFE, 1'b1);
        edge_chk("wrap ffff", 16'hFFFF, 1'b1);
        chk("wrap plus1", if_pc_plus1, 16'h0000);
        chk("wrap im_addr", im_addr, 16'h0000);
        edge_chk("wrap 0000", 16'h0000, 1'b1);
        chk("wrap0 plus1", if_pc_plus1, 16'h0001);

        @(negedge clk);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
        edge_chk("redir+stall", 16'h0000, 1'b0);
        chk("redir+stall im_addr", im_addr, 16'h0200);
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0;
        edge_chk("redir+stall target", 16'h0200, 1'b1);

        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0014;
        @(negedge clk);
        redirect = 1'b0;
        stall = 1'b1;
        edge_chk("stall at 20", 16'h0200, 1'b0);
        chk("stall at 20 im_addr", im_addr, 16'h0014);
        rst_n = 1'b0;
        #1;
        chk("async rst if_pc", if_pc, 16'h0000);
        chk("async rst if_pc_plus1", if_pc_plus1, 16'h0001);
        chk("async rst if_instr", if_instr, 16'h0000);
        chk("async rst if_valid", {15'd0, if_valid}, 16'h0000);
        chk("async rst im_addr", im_addr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        edge_chk("restart", 16'h0000, 1'b1);

        hlt_on = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) edge_chk("pre-hlt", 16'(k), 1'b1);
        edge_chk("hlt word", 16'h0006, 1'b1);
        chk("hlt word if_instr", if_instr, 16'hF000);
`ifdef IF_HALT_DETECT_EN
        chk("hlt halted", {15'd0, halted}, 16'h0001);
        chk("hlt im_rd_en", {15'd0, im_rd_en}, 16'h0000);
        chk("hlt im_addr", im_addr, 16'h0006);
        edge_chk("halted idle", 16'h0006, 1'b0);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0100;
        edge_chk("halted redirect", 16'h0006, 1'b0);
        chk("halted redirect im_addr", im_addr, 16'h0006);
        chk("halted redirect halted", {15'd0, halted}, 16'h0001);
        @(negedge clk);
        redirect = 1'b0;

        do_reset();
        for (int k = 0; k < 6; k++) edge_chk("pre-hlt2", 16'(k), 1'b1);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0030;
        edge_chk("hlt squashed", 16'h0005, 1'b0);
        chk("hlt squashed halted", {15'd0, halted}, 16'h0000);
        @(negedge clk);
        redirect = 1'b0;
        edge_chk("hlt squash target", 16'h0030, 1'b1);
`else
        chk("hlt passthru halted", {15'd0, halted}, 16'h0000);
        chk("hlt passthru im_rd_en", {15'd0, im_rd_en}, 16'h0001);
        edge_chk("after hlt word", 16'h0007, 1'b1);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
